// File: rtl/tile_render_pipe_if.sv
// tile_render_pipe_if: pixel stream, memory, cursor and palette-write bundle of the render stage
// master: timing generator / memories / CPU side; slave: tile_render_pipe
// in to pipe: drawX/drawY/syncs/vde_in, map_rdata, rom_rdata, cursor_col/row, pal_we/addr/wdata
// out of pipe: map_addr, rom_addr, red/green/blue, hsync/vsync/vde
interface tile_render_pipe_if;
  logic [9:0] drawX, drawY;
  logic hsync_in, vsync_in, vde_in;
  logic [10:0] map_addr;
  logic [7:0] map_rdata;
  logic [15:0] rom_addr;
  logic [3:0] rom_rdata;
  logic [5:0] cursor_col;
  logic [4:0] cursor_row;
  logic pal_we;
  logic [3:0] pal_addr;
  logic [23:0] pal_wdata;
  logic [7:0] red, green, blue;
  logic hsync, vsync, vde;
  modport master (
    output drawX, drawY, hsync_in, vsync_in, vde_in, map_rdata, rom_rdata,
           cursor_col, cursor_row, pal_we, pal_addr, pal_wdata,
    input  map_addr, rom_addr, red, green, blue, hsync, vsync, vde
  );
  modport slave (
    input  drawX, drawY, hsync_in, vsync_in, vde_in, map_rdata, rom_rdata,
           cursor_col, cursor_row, pal_we, pal_addr, pal_wdata,
    output map_addr, rom_addr, red, green, blue, hsync, vsync, vde
  );
endinterface

// File: rtl/tile_render_pipe.sv
// tile_render_pipe: 3-cycle tile-map -> sprite ROM -> palette renderer with cursor outline
// clk_25MHz/reset: pixel clock, sync active-high reset; bus: tile_render_pipe_if.slave
module tile_render_pipe #(
  parameter int MAP_COLS = 40,
  parameter int MAP_ROWS = 30,
  parameter logic [23:0] BG_COLOR = 24'h202020,
  parameter logic [23:0] CURSOR_COLOR = 24'hFFFF00
) (
  input logic clk_25MHz,
  input logic reset,
  tile_render_pipe_if.slave bus
);
  localparam logic [5:0] COLS = 6'(MAP_COLS);
  localparam logic [4:0] ROWS = 5'(MAP_ROWS);
  localparam logic [9:0] XPIX = 10'(MAP_COLS * 16);
  localparam logic [9:0] YPIX = 10'(MAP_ROWS * 16);
  logic [5:0] col, row;
  logic [3:0] xoff_q, yoff_q;
  logic hit1_q, inmap1_q, vde1_q, hs1_q, vs1_q;
  logic [7:0] elem_q;
  logic hit2_q, inmap2_q, vde2_q, hs2_q, vs2_q;
  logic [23:0] rgb_q;
  logic hs_q, vs_q, vde_q;
  logic [23:0] pal_q [16];
  logic hit_d, inmap_d;
  logic [23:0] color_d;
  assign col = bus.drawX[9:4];
  assign row = bus.drawY[9:4];
  // row*40 as row*32 + row*8
  assign bus.map_addr = {row, 5'b0} + {2'b0, row, 3'b0} + {5'b0, col};
  assign bus.rom_addr = {bus.map_rdata, yoff_q, xoff_q};
  // out-of-range cursor never matches, so no outline appears anywhere
  assign hit_d = col == bus.cursor_col && row == {1'b0, bus.cursor_row} &&
                 bus.cursor_col < COLS && bus.cursor_row < ROWS &&
                 (~|bus.drawX[3:0] || &bus.drawX[3:0] || ~|bus.drawY[3:0] || &bus.drawY[3:0]);
  assign inmap_d = bus.drawX < XPIX && bus.drawY < YPIX;
  always_comb begin
    color_d = !vde2_q ? 24'h000000 :
              !inmap2_q ? BG_COLOR :
              hit2_q ? CURSOR_COLOR :
              elem_q == 8'd0 ? BG_COLOR :
              bus.rom_rdata == 4'd0 ? BG_COLOR : pal_q[bus.rom_rdata];
  end
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      {xoff_q, yoff_q, hit1_q, inmap1_q, vde1_q, hs1_q, vs1_q} <= '0;
      {elem_q, hit2_q, inmap2_q, vde2_q, hs2_q, vs2_q} <= '0;
      {rgb_q, hs_q, vs_q, vde_q} <= '0;
      for (int i = 0; i < 16; i++) pal_q[i] <= {3{i[3:0], i[3:0]}};
    end else begin
      xoff_q <= bus.drawX[3:0];
      yoff_q <= bus.drawY[3:0];
      hit1_q <= hit_d;
      inmap1_q <= inmap_d;
      vde1_q <= bus.vde_in;
      hs1_q <= bus.hsync_in;
      vs1_q <= bus.vsync_in;
      elem_q <= bus.map_rdata;
      hit2_q <= hit1_q;
      inmap2_q <= inmap1_q;
      vde2_q <= vde1_q;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      rgb_q <= color_d;
      hs_q <= hs2_q;
      vs_q <= vs2_q;
      vde_q <= vde2_q;
      if (bus.pal_we) pal_q[bus.pal_addr] <= bus.pal_wdata;
    end
  end
  assign {bus.red, bus.green, bus.blue} = rgb_q;
  assign bus.hsync = hs_q;
  assign bus.vsync = vs_q;
  assign bus.vde = vde_q;
endmodule

// File: tb/tb_tile_render_pipe.sv
// tb_tile_render_pipe: table-driven scoreboard bench for tile_render_pipe
module tb_tile_render_pipe;
  logic clk_25MHz = 0;
  logic reset = 1;
  always #5 clk_25MHz = ~clk_25MHz;
  tile_render_pipe_if bus();
  tile_render_pipe dut (.clk_25MHz(clk_25MHz), .reset(reset), .bus(bus));
  typedef struct {
    logic [9:0] x, y;
    logic vde, hs, vs;
    logic [5:0] ccol;
    logic [4:0] crow;
    logic [7:0] elem;
    logic [3:0] pix;
    logic [23:0] exp;
  } vec_t;
  typedef struct {
    logic [23:0] rgb;
    logic hs, vs, vde;
    int due;
  } sb_t;
  sb_t q[$];
  vec_t p1, p2;
  bit v1;
  int cyc, checks, failures;
  function automatic vec_t mk(int x, int y, bit vde, bit hs, bit vs, int ccol, int crow,
                              int elem, int pix, logic [23:0] e);
    vec_t r;
    r.x = 10'(x); r.y = 10'(y); r.vde = vde; r.hs = hs; r.vs = vs;
    r.ccol = 6'(ccol); r.crow = 5'(crow); r.elem = 8'(elem); r.pix = 4'(pix); r.exp = e;
    return r;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %h expected %h", n, cyc, a, e);
    end
  endtask
  task automatic step(input vec_t v, input bit push, input bit we, input bit rst_v, input bit chk0);
    @(negedge clk_25MHz);
    cyc++;
    if (chk0) begin
      chk("rst_rgb", 32'({bus.red, bus.green, bus.blue}), 32'd0);
      chk("rst_sync", 32'({bus.hsync, bus.vsync, bus.vde}), 32'd0);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      sb_t s;
      s = q.pop_front();
      chk("rgb", 32'({bus.red, bus.green, bus.blue}), 32'(s.rgb));
      chk("hsync", 32'(bus.hsync), 32'(s.hs));
      chk("vsync", 32'(bus.vsync), 32'(s.vs));
      chk("vde", 32'(bus.vde), 32'(s.vde));
    end
    reset = rst_v;
    bus.drawX = v.x; bus.drawY = v.y;
    bus.vde_in = v.vde; bus.hsync_in = v.hs; bus.vsync_in = v.vs;
    bus.cursor_col = v.ccol; bus.cursor_row = v.crow;
    bus.map_rdata = p1.elem;
    bus.rom_rdata = p2.pix;
    bus.pal_we = we; bus.pal_addr = 4'd5; bus.pal_wdata = 24'hFF0000;
    #1;
    if (push) begin
      chk("map_addr", 32'(bus.map_addr), 32'(int'(v.y >> 4) * 40 + int'(v.x >> 4)));
      q.push_back('{v.exp, v.hs, v.vs, v.vde, cyc + 3});
    end
    if (v1) chk("rom_addr", 32'(bus.rom_addr), 32'({p1.elem, p1.y[3:0], p1.x[3:0]}));
    p2 = p1;
    p1 = v;
    v1 = push;
  endtask
  vec_t tbl[14];
  vec_t rv, idle, pa, pc, d2, d3;
  initial begin
    tbl[0]  = mk(17, 33, 1, 1, 0, 1, 2, 7, 5, 24'h555555);
    tbl[1]  = mk(16, 40, 1, 0, 1, 1, 2, 7, 5, 24'hFFFF00);
    tbl[2]  = mk(16, 40, 1, 1, 1, 45, 2, 3, 9, 24'h999999);
    tbl[3]  = mk(100, 100, 1, 0, 0, 1, 2, 0, 9, 24'h202020);
    tbl[4]  = mk(120, 80, 1, 1, 0, 1, 2, 7, 0, 24'h202020);
    tbl[5]  = mk(700, 10, 0, 0, 1, 1, 2, 7, 5, 24'h000000);
    tbl[6]  = mk(640, 0, 1, 1, 1, 1, 2, 7, 5, 24'h202020);
    tbl[7]  = mk(0, 480, 1, 0, 0, 1, 2, 7, 5, 24'h202020);
    tbl[8]  = mk(639, 479, 1, 1, 0, 39, 29, 255, 15, 24'hFFFF00);
    tbl[9]  = mk(631, 471, 1, 0, 1, 39, 29, 255, 15, 24'hFFFFFF);
    tbl[10] = mk(47, 32, 1, 1, 1, 2, 2, 1, 1, 24'hFFFF00);
    tbl[11] = mk(47, 32, 1, 0, 0, 3, 2, 1, 1, 24'h111111);
    tbl[12] = mk(300, 200, 1, 1, 0, 1, 2, 2, 10, 24'hAAAAAA);
    tbl[13] = mk(16, 40, 0, 1, 1, 1, 2, 7, 5, 24'h000000);
    rv   = mk(17, 33, 1, 1, 1, 1, 2, 7, 5, 24'h0);
    idle = mk(0, 0, 0, 0, 0, 1, 2, 0, 0, 24'h0);
    pa   = mk(17, 33, 1, 0, 0, 1, 2, 7, 5, 24'h555555);
    pc   = mk(200, 200, 1, 1, 1, 1, 2, 9, 5, 24'hFF0000);
    d2   = mk(47, 32, 1, 1, 0, 2, 2, 1, 1, 24'hFFFF00);
    d3   = mk(300, 200, 1, 0, 1, 1, 2, 2, 10, 24'hAAAAAA);
    p1 = rv; p2 = rv;
    bus.pal_we = 0; bus.vde_in = 1; bus.hsync_in = 1; bus.vsync_in = 1;
    bus.drawX = 10'd17; bus.drawY = 10'd33; bus.cursor_col = 6'd1; bus.cursor_row = 5'd2;
    bus.map_rdata = 8'd7; bus.rom_rdata = 4'd5; bus.pal_addr = 4'd5; bus.pal_wdata = 24'hFF0000;
    step(rv, 0, 0, 1, 1);
    step(rv, 0, 0, 0, 1);
    step(rv, 0, 0, 0, 1);
    foreach (tbl[i]) step(tbl[i], 1, 0, 0, 0);
    step(pa, 1, 0, 0, 0);
    step(mk(17, 33, 1, 1, 0, 1, 2, 7, 5, 24'hFF0000), 1, 0, 0, 0);
    step(pc, 1, 1, 0, 0);
    step(pa, 0, 0, 0, 0);
    step(pa, 0, 0, 0, 0);
    step(pa, 0, 0, 1, 0);
    step(pa, 1, 0, 0, 1);
    step(d2, 1, 0, 0, 1);
    step(d3, 1, 0, 0, 1);
    repeat (4) step(idle, 0, 0, 0, 0);
    chk("drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
